regs_arbiter: RTL
=================

Name: regs_arbiter

Overview:
Sequencing arbiter in front of the shared TCPC register bank's single-port access interface (REQUEST/RWN/ADDR/WR_DATA in; RD_DATA/ACK out).
- Serves four clients: Tx, Rx, HReset, tcpm.
- Grants the bank to one client at a time, round-robin, and holds the transaction until the bank ACKs or a timeout fires.
- Returns read data, a per-client one-cycle ACK and an error flag.

Parameters:
- TIMEOUT_CYC, 16: max cycles waiting for bank ACK; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYC < 2^TO_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_Tx, REQ_Rx, REQ_HReset, REQ_tcpm  in  1 each  client access request, level.
- RWN_Tx, RWN_Rx, RWN_HReset, RWN_tcpm  in  1 each  1 = read, 0 = write.
- ADDR_Tx, ADDR_Rx, ADDR_HReset, ADDR_tcpm  in  8 each  register address.
- WR_DATA_Tx, WR_DATA_Rx, WR_DATA_HReset, WR_DATA_tcpm  in  16 each  write data.
- ACK_Tx, ACK_Rx, ACK_HReset, ACK_tcpm  out  1 each  one-cycle completion pulse.
- RD_DATA_OUT  out  16  read data; valid in the ACK_x cycle, held until the next completion.
- ERR  out  1  valid with ACK_x: 1 = timed out.
- REQUEST  out  1  to bank: access strobe, level.
- RWN  out  1  to bank.
- ADDR  out  8  to bank.
- WR_DATA  out  16  to bank.
- RD_DATA  in  16  from bank.
- ACK  in  1  from bank: transfer done.

Behaviour:
- Reset (async, RST_N=0):
  - REQUEST=0, RWN=1, ADDR=0, WR_DATA=0, all ACK_x=0, RD_DATA_OUT=0, ERR=0.
  - State IDLE, rr pointer=0 (Tx), timeout counter=0.
  - Applies immediately, including mid-transaction; the aborted transaction gets no ACK_x.
- Client index: 0=Tx, 1=Rx, 2=HReset, 3=tcpm.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any REQ_x is high at edge N, the winner is the first requesting index at or after the pointer, wrapping mod 4.
  - At edge N the winner's RWN/ADDR/WR_DATA are registered onto the bank outputs, REQUEST goes to 1 and the state moves to BUSY. REQUEST is therefore visible in cycle N+1.
  - Bank ACK seen in IDLE is ignored.
- BUSY:
  - REQUEST, RWN, ADDR and WR_DATA are held stable; client inputs are not re-sampled.
  - The counter increments each cycle.
  - On ACK=1: REQUEST<=0; RD_DATA_OUT<=RD_DATA for reads (unchanged for writes); ERR<=0; ACK_winner<=1 for exactly one cycle; pointer<=winner+1 mod 4; go to RELEASE.
  - Timeout (TIMEOUT_CYC≠0) when counter==TIMEOUT_CYC-1 with no ACK: REQUEST<=0; ERR<=1; RD_DATA_OUT<=16'hFFFF for reads; ACK_winner pulses; pointer advances; go to RELEASE.
  - ACK and timeout in the same cycle: ACK wins, ERR=0.
  - Client dropping REQ_x during BUSY is ignored; the transaction completes and ACK_x still pulses.
- RELEASE:
  - The counter is cleared.
  - Stay while bank ACK=1 (ACK held high); go to IDLE once ACK=0.
  - Minimum inter-transaction gap is 1 idle cycle.
- Client obligations:
  - A client must drop REQ_x in the cycle after it sees ACK_x.
  - A REQ_x still high in IDLE is treated as a new request.
- At most one ACK_x is high in any cycle. ERR is only meaningful in an ACK_x cycle and is 0 otherwise.

Optional Feature:
- Macro: HRESET_PRIO_EN.
- Defined: in IDLE, REQ_HReset wins over all other requests regardless of the pointer. A HReset grant does not advance the pointer. Other clients keep round-robin order among themselves.
- Undefined: pure 4-way round-robin; HReset has no special status.

Decomposition:
- Package regs_arb_pkg:
  - NUM_CLIENTS=4.
  - Client index constants CL_TX=0, CL_RX=1, CL_HRESET=2, CL_TCPM=3.
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_RELEASE).
  - Read-timeout fill constant RD_ERR_VAL=16'hFFFF.
- Sub-module rr_picker4: combinational; 4-bit request vector + 2-bit pointer in, one-hot grant + 2-bit index out. Unit-testable on its own.

Test Plan:
- Single read: after reset, REQ_Rx=1, RWN_Rx=1, ADDR_Rx=8'h10; bank ACKs 3 cycles after REQUEST with RD_DATA=16'hBEEF -> REQUEST high 1 cycle after REQ, ADDR=8'h10, RWN=1; ACK_Rx pulses once, RD_DATA_OUT=16'hBEEF, ERR=0.
- Fairness: all four REQ_x held high, bank ACKs 1 cycle after REQUEST -> grants in order Tx, Rx, HReset, tcpm, Tx; exactly one ACK_x per transaction; REQUEST low for ≥1 cycle between grants.
- Timeout: REQ_tcpm write with ADDR_tcpm=8'h20, WR_DATA_tcpm=16'h1234; bank never ACKs; TIMEOUT_CYC=16 -> REQUEST drops after 16 cycles high; ACK_tcpm=1 with ERR=1; next request is served normally.
- Stuck bank ACK: bank holds ACK high 5 cycles -> FSM stays in RELEASE; no new REQUEST until ACK=0.
- Reset mid-BUSY: RST_N=0 while REQUEST=1 -> REQUEST=0 immediately, no ACK_x; after release, a pending REQ_Tx is granted first.
- HRESET_PRIO_EN defined: pointer at Rx, REQ_Rx and REQ_HReset both high -> HReset granted first, then Rx.

Source files
------------

// File: rtl/regs_arb_pkg.sv
// Shared constants and types for the TCPC register-bank arbiter.
// Client indices, FSM encoding and the read-timeout fill value.
package regs_arb_pkg;

  localparam int unsigned NUM_CLIENTS = 4;

  localparam logic [1:0] CL_TX     = 2'd0;
  localparam logic [1:0] CL_RX     = 2'd1;
  localparam logic [1:0] CL_HRESET = 2'd2;
  localparam logic [1:0] CL_TCPM   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [15:0] RD_ERR_VAL = 16'hFFFF;

  // Round-robin successor of a client index (wraps mod 4).
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_picker4.sv
// Combinational 4-way round-robin picker: first requester at or after ptr, wrapping.
// gnt is one-hot (all zero when nothing requests); idx is its encoded form.
module rr_picker4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt   = 4'b0000;
    idx   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/regs_arbiter.sv
// Round-robin arbiter in front of the single-port TCPC register bank (Tx, Rx, HReset, tcpm).
// Optional macro HRESET_PRIO_EN: HReset requests win in IDLE and do not advance the pointer.
module regs_arbiter
  import regs_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned TO_W        = 8
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        REQ_Tx,
  input  logic        REQ_Rx,
  input  logic        REQ_HReset,
  input  logic        REQ_tcpm,
  input  logic        RWN_Tx,
  input  logic        RWN_Rx,
  input  logic        RWN_HReset,
  input  logic        RWN_tcpm,
  input  logic [7:0]  ADDR_Tx,
  input  logic [7:0]  ADDR_Rx,
  input  logic [7:0]  ADDR_HReset,
  input  logic [7:0]  ADDR_tcpm,
  input  logic [15:0] WR_DATA_Tx,
  input  logic [15:0] WR_DATA_Rx,
  input  logic [15:0] WR_DATA_HReset,
  input  logic [15:0] WR_DATA_tcpm,

  output logic        ACK_Tx,
  output logic        ACK_Rx,
  output logic        ACK_HReset,
  output logic        ACK_tcpm,
  output logic [15:0] RD_DATA_OUT,
  output logic        ERR,

  output logic        REQUEST,
  output logic        RWN,
  output logic [7:0]  ADDR,
  output logic [15:0] WR_DATA,
  input  logic [15:0] RD_DATA,
  input  logic        ACK
);

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

  logic [3:0]        req_vec;
  logic [3:0]        rwn_vec;
  logic [3:0][7:0]   addr_vec;
  logic [3:0][15:0]  wd_vec;

  assign req_vec  = {REQ_tcpm, REQ_HReset, REQ_Rx, REQ_Tx};
  assign rwn_vec  = {RWN_tcpm, RWN_HReset, RWN_Rx, RWN_Tx};
  assign addr_vec = {ADDR_tcpm, ADDR_HReset, ADDR_Rx, ADDR_Tx};
  assign wd_vec   = {WR_DATA_tcpm, WR_DATA_HReset, WR_DATA_Rx, WR_DATA_Tx};

  arb_state_e      state;
  logic [1:0]      ptr;
  logic [TO_W-1:0] cnt;
  logic [1:0]      win_q;
  logic            adv_q;
  logic [3:0]      ack_q;

  logic [3:0] pick_gnt;
  logic [1:0] pick_idx;
  logic       any_req;
  logic [1:0] win_idx;
  logic       win_adv;
  logic       timeout_hit;

  rr_picker4 u_picker (
    .req (req_vec),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign any_req = |pick_gnt;

  always_comb begin
    win_idx = pick_idx;
    win_adv = 1'b1;
`ifdef HRESET_PRIO_EN
    // HReset pre-empts the rotation and leaves the pointer where it was.
    if (req_vec[CL_HRESET]) begin
      win_idx = CL_HRESET;
      win_adv = 1'b0;
    end
`endif
  end

  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      ptr         <= CL_TX;
      cnt         <= '0;
      win_q       <= CL_TX;
      adv_q       <= 1'b1;
      ack_q       <= 4'b0000;
      REQUEST     <= 1'b0;
      RWN         <= 1'b1;
      ADDR        <= 8'h00;
      WR_DATA     <= 16'h0000;
      RD_DATA_OUT <= 16'h0000;
      ERR         <= 1'b0;
    end else begin
      ack_q <= 4'b0000;
      ERR   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (any_req) begin
            win_q   <= win_idx;
            adv_q   <= win_adv;
            REQUEST <= 1'b1;
            RWN     <= rwn_vec[win_idx];
            ADDR    <= addr_vec[win_idx];
            WR_DATA <= wd_vec[win_idx];
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          // A bank ACK in the timeout cycle still counts as a clean completion.
          if (ACK) begin
            REQUEST      <= 1'b0;
            ack_q[win_q] <= 1'b1;
            if (RWN) RD_DATA_OUT <= RD_DATA;
            if (adv_q) ptr <= next_ptr(win_q);
            state <= ST_RELEASE;
          end else if (timeout_hit) begin
            REQUEST      <= 1'b0;
            ack_q[win_q] <= 1'b1;
            ERR          <= 1'b1;
            if (RWN) RD_DATA_OUT <= RD_ERR_VAL;
            if (adv_q) ptr <= next_ptr(win_q);
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          cnt <= '0;
          // A bank holding ACK high must not leak into the next transaction.
          if (!ACK) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ACK_Tx     = ack_q[CL_TX];
  assign ACK_Rx     = ack_q[CL_RX];
  assign ACK_HReset = ack_q[CL_HRESET];
  assign ACK_tcpm   = ack_q[CL_TCPM];

endmodule
